mem_access_unit: RTL and testbench

Load/store initiator for the core's MEM stage: accepts one RISC-V load or store from execute, drives the word-wide data memory port (`mar`, `mdr`, `isld`, `isSt`, `ldresult`), and returns sign/zero-extended load data or a store completion. Handles byte and halfword accesses, performing read-modify-write for SB/SH because the data memory only writes whole words. Sits between the execute/MEM pipeline register and the `Datamemory` responder. Its one-cycle registered read latency is fixed.

---
 rtl/mau_pkg.sv | 35 +++
 rtl/mau_align.sv | 39 +++
 rtl/mem_access_unit.sv | 175 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mau_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 codes,
// FSM state encoding and request legality decode.
package mau_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RD_WAIT,
    S_WR,
    S_ERR
  } state_e;

  // Unsupported width code or a lane offset not aligned to the access size.
  function automatic logic req_illegal(input logic we, input logic [2:0] f3,
                                       input logic [1:0] lane);
    logic bad;
    bad = 1'b1;
    case (f3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = lane[0];
      F3_W:    bad = (lane != 2'b00);
      F3_BU:   bad = we;
      F3_HU:   bad = we | lane[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mau_align.sv
// Byte/halfword lane handling: extract-and-extend for loads and
// lane merge into the fetched word for sub-word stores.
module mau_align
  import mau_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_ext_c_o,
  output logic [31:0] store_merged_c_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{lane_i, 3'b000} +: 8];
    half_sel = rdata_i[{lane_i[1], 4'b0000} +: 16];
    case (funct3_i)
      F3_B:    load_ext_c_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_ext_c_o = {24'h000000, byte_sel};
      F3_H:    load_ext_c_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_ext_c_o = {16'h0000, half_sel};
      default: load_ext_c_o = rdata_i;
    endcase
  end

  // Untouched lanes keep the value just read from memory.
  always_comb begin
    store_merged_c_o = rdata_i;
    case (funct3_i)
      F3_B:    store_merged_c_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      F3_H:    store_merged_c_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: store_merged_c_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator driving a word-wide data memory with a
// one-cycle registered read; sub-word stores are done as read-modify-write.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned ADDR_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        resp_err,
  output logic [31:0] mar,
  output logic [31:0] mdr,
  output logic        isld,
  output logic        isSt,
  input  logic [31:0] ldresult
);

  state_e state_q, state_d;

  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;
  logic [4:0]  rd_q;

  logic        isld_q, isld_d, isst_q, isst_d;
  logic [31:0] mar_q, mar_d, mdr_q, mdr_d;
  logic        resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic [4:0]  resp_rd_q, resp_rd_d;

  logic        accept_c, req_err_c, req_sw_c;
  logic [31:0] word_addr_c, load_ext_c, store_merged_c;
  logic        unused_addr;

  assign req_ready   = (state_q == S_IDLE) && !rst;
  assign accept_c    = req_valid && req_ready;
  assign req_err_c   = req_illegal(req_we, req_funct3, req_addr[1:0]);
  assign req_sw_c    = req_we && (req_funct3 == F3_W);
  assign word_addr_c = 32'(req_addr[ADDR_W-1:2]);
  assign unused_addr = ^req_addr;

  mau_align u_align (
    .rdata_i          (ldresult),
    .lane_i           (lane_q),
    .funct3_i         (f3_q),
    .wdata_i          (wdata_q),
    .load_ext_c_o     (load_ext_c),
    .store_merged_c_o (store_merged_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          if (req_err_c)     state_d = S_ERR;
          else if (req_sw_c) state_d = S_WR;
          else               state_d = S_RD;
        end
      end
      S_RD:      state_d = S_RD_WAIT;
      S_RD_WAIT: state_d = we_q ? S_WR : S_IDLE;
      S_WR:      state_d = S_IDLE;
      S_ERR:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Next values of the registered memory-port and response outputs.
  always_comb begin
    isld_d       = 1'b0;
    isst_d       = 1'b0;
    mar_d        = mar_q;
    mdr_d        = mdr_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_data_d  = resp_data_q;
    resp_rd_d    = resp_rd_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          if (req_err_c) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_data_d  = 32'h0;
            resp_rd_d    = req_rd;
          end else if (req_sw_c) begin
            isst_d = 1'b1;
            mar_d  = word_addr_c;
            mdr_d  = req_wdata;
          end else begin
            isld_d = 1'b1;
            mar_d  = word_addr_c;
          end
        end
      end
      S_RD_WAIT: begin
        if (we_q) begin
          isst_d = 1'b1;
          mdr_d  = store_merged_c;
        end else begin
          resp_valid_d = 1'b1;
          resp_data_d  = load_ext_c;
          resp_rd_d    = rd_q;
        end
      end
      S_WR: begin
        resp_valid_d = 1'b1;
        resp_data_d  = 32'h0;
        resp_rd_d    = rd_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      isld_q       <= 1'b0;
      isst_q       <= 1'b0;
      mar_q        <= 32'h0;
      mdr_q        <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= 32'h0;
      resp_rd_q    <= 5'd0;
      we_q         <= 1'b0;
      f3_q         <= 3'd0;
      lane_q       <= 2'd0;
      wdata_q      <= 32'h0;
      rd_q         <= 5'd0;
    end else begin
      isld_q       <= isld_d;
      isst_q       <= isst_d;
      mar_q        <= mar_d;
      mdr_q        <= mdr_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_data_q  <= resp_data_d;
      resp_rd_q    <= resp_rd_d;
      if (accept_c) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        lane_q  <= req_addr[1:0];
        wdata_q <= req_wdata;
        rd_q    <= req_rd;
      end
    end
  end

  assign isld       = isld_q;
  assign isSt       = isst_q;
  assign mar        = mar_q;
  assign mdr        = mdr_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_data  = resp_data_q;
  assign resp_rd    = resp_rd_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a 16-word data memory responder, a per-cycle
// expectation timeline built from an architectural model, and a compare process.
module tb_mem_access_unit;
  import mau_pkg::*;

  localparam int NC = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [4:0]  req_rd = 5'd0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_err;
  logic [31:0] mar, mdr;
  logic        isld, isSt;
  logic [31:0] ldresult = 32'h0;

  mem_access_unit #(.ADDR_W(6)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_rd(resp_rd), .resp_err(resp_err),
    .mar(mar), .mdr(mdr), .isld(isld), .isSt(isSt), .ldresult(ldresult)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Data memory responder: no reset, one-cycle registered read.
  logic [31:0] dmem [16];
  always @(posedge clk) begin
    if (isSt) dmem[mar[3:0]] <= mdr;
    if (isld) ldresult <= dmem[mar[3:0]];
  end

  logic [31:0] ref_mem [16];
  bit          exp_ld [NC];
  bit          exp_st [NC];
  bit          exp_rv [NC];
  bit          exp_err [NC];
  bit          exp_rst [NC];
  bit          exp_ready [NC];
  logic [31:0] exp_mar [NC];
  logic [31:0] exp_mdr [NC];
  logic [31:0] exp_data [NC];
  logic [4:0]  exp_rd [NC];
  int          free_cyc = 0;
  bit          chk_en = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && cyc < NC) begin
      if (exp_rst[cyc]) begin
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_isld", 32'(isld), 32'h0);
        chk("rst_isSt", 32'(isSt), 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_err", 32'(resp_err), 32'h0);
        chk("rst_resp_data", resp_data, 32'h0);
        chk("rst_resp_rd", 32'(resp_rd), 32'h0);
        chk("rst_mar", mar, 32'h0);
        chk("rst_mdr", mdr, 32'h0);
      end else begin
        chk("req_ready", 32'(req_ready), 32'(exp_ready[cyc]));
        chk("isld", 32'(isld), 32'(exp_ld[cyc]));
        chk("isSt", 32'(isSt), 32'(exp_st[cyc]));
        if (exp_ld[cyc] || exp_st[cyc]) chk("mar", mar, exp_mar[cyc]);
        if (exp_st[cyc]) chk("mdr", mdr, exp_mdr[cyc]);
        chk("resp_valid", 32'(resp_valid), 32'(exp_rv[cyc]));
        if (exp_rv[cyc]) begin
          chk("resp_err", 32'(resp_err), 32'(exp_err[cyc]));
          chk("resp_data", resp_data, exp_data[cyc]);
          chk("resp_rd", 32'(resp_rd), 32'(exp_rd[cyc]));
        end
      end
    end
  end

  // Architectural model: what each request must do and on which cycles.
  task automatic model_issue(input int x, input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [4:0] rd, output int free, output int rvc,
                             output int stc);
    int idx, off, size;
    bit legal;
    logic [31:0] w, v, mask;
    idx  = int'(addr[5:2]);
    off  = int'(addr[1:0]);
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    if (we) legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (f3[1:0] == 2'd3) legal = 1'b0;
    if (legal && (off % size) != 0) legal = 1'b0;
    w   = ref_mem[idx];
    stc = -1;
    if (!legal) begin
      rvc = x + 1; free = x + 2;
      exp_err[rvc] = 1'b1; exp_data[rvc] = 32'h0;
    end else if (we && size == 4) begin
      stc = x + 1; rvc = x + 2; free = x + 2;
      exp_mdr[stc] = wdata; exp_data[rvc] = 32'h0;
      ref_mem[idx] = wdata;
    end else if (!we) begin
      rvc = x + 3; free = x + 3;
      exp_ld[x + 1] = 1'b1; exp_mar[x + 1] = 32'(idx);
      v = w >> (8 * off);
      if (size == 1) begin
        v = v & 32'h000000FF;
        if (!f3[2] && v[7]) v = v | 32'hFFFFFF00;
      end else if (size == 2) begin
        v = v & 32'h0000FFFF;
        if (!f3[2] && v[15]) v = v | 32'hFFFF0000;
      end
      exp_data[rvc] = v;
    end else begin
      stc = x + 3; rvc = x + 4; free = x + 4;
      exp_ld[x + 1] = 1'b1; exp_mar[x + 1] = 32'(idx);
      mask = ((size == 1) ? 32'h000000FF : 32'h0000FFFF) << (8 * off);
      v = (w & ~mask) | ((wdata << (8 * off)) & mask);
      exp_mdr[stc] = v; exp_data[rvc] = 32'h0;
      ref_mem[idx] = v;
    end
    if (stc >= 0) begin
      exp_st[stc] = 1'b1; exp_mar[stc] = 32'(idx);
    end
    exp_rv[rvc] = 1'b1;
    exp_rd[rvc] = rd;
    for (int k = x + 1; k < free; k++) exp_ready[k] = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd,
                       output logic [31:0] got_data, output logic got_err,
                       output logic [31:0] got_mdr);
    int x, free, rvc, stc;
    while (cyc < free_cyc) step();
    x = cyc;
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    model_issue(x, we, f3, addr, wdata, rd, free, rvc, stc);
    free_cyc = free;
    got_data = 32'h0; got_err = 1'b0; got_mdr = 32'h0;
    while (cyc < free) begin
      step();
      if (cyc == rvc) begin
        got_data = resp_data;
        got_err  = resp_err;
      end
      if (cyc == stc) got_mdr = mdr;
      // Requests presented while busy must be ignored.
      if (cyc < free && $urandom_range(0, 3) == 0) begin
        req_valid  = 1'b1;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_rd     = 5'($urandom);
      end else begin
        req_valid = 1'b0;
      end
    end
  endtask

  task automatic rst_during_sb(input logic [31:0] addr, input logic [31:0] wdata);
    int x, free, rvc, stc, idx;
    logic [31:0] saved;
    while (cyc < free_cyc) step();
    x = cyc;
    idx = int'(addr[5:2]);
    saved = ref_mem[idx];
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_B;
    req_addr = addr; req_wdata = wdata; req_rd = 5'd9;
    model_issue(x, 1'b1, F3_B, addr, wdata, 5'd9, free, rvc, stc);
    exp_st[x + 3] = 1'b0; exp_rv[x + 4] = 1'b0;
    exp_rst[x + 3] = 1'b1;
    ref_mem[idx] = saved;
    free_cyc = x + 4;
    step(); req_valid = 1'b0;
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    step();
  endtask

  logic [31:0] d, m;
  logic        e;

  initial begin
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      dmem[i] <= ref_mem[i];
    end
    for (int i = 0; i < NC; i++) exp_ready[i] = 1'b1;
    exp_rst[1] = 1'b1;
    exp_rst[2] = 1'b1;
    chk_en = 1'b1;
    step();
    step();
    rst = 1'b0;
    free_cyc = 3;

    issue(1'b1, F3_W, 32'h04, 32'hCAFEBABE, 5'd1, d, e, m);
    chk("sw_mdr", m, 32'hCAFEBABE);
    chk("sw_err", 32'(e), 32'h0);
    issue(1'b0, F3_B, 32'h07, 32'h0, 5'd2, d, e, m);
    chk("lb_07", d, 32'hFFFFFFCA);
    issue(1'b0, F3_BU, 32'h07, 32'h0, 5'd3, d, e, m);
    chk("lbu_07", d, 32'h000000CA);
    issue(1'b0, F3_HU, 32'h04, 32'h0, 5'd4, d, e, m);
    chk("lhu_04", d, 32'h0000BABE);
    issue(1'b1, F3_H, 32'h06, 32'h00001234, 5'd5, d, e, m);
    chk("sh_06_mdr", m, 32'h1234BABE);
    issue(1'b0, F3_W, 32'h04, 32'h0, 5'd6, d, e, m);
    chk("lw_04", d, 32'h1234BABE);
    issue(1'b0, F3_W, 32'h02, 32'h0, 5'd7, d, e, m);
    chk("lw_02_err", 32'(e), 32'h1);
    chk("lw_02_data", d, 32'h0);
    issue(1'b0, 3'b011, 32'h00, 32'h0, 5'd8, d, e, m);
    chk("f3_011_err", 32'(e), 32'h1);
    issue(1'b1, F3_W, 32'h08, 32'h0BADF00D, 5'd10, d, e, m);
    rst_during_sb(32'h09, 32'h000000A5);
    issue(1'b0, F3_W, 32'h08, 32'h0, 5'd11, d, e, m);
    chk("sb_rst_word", d, 32'h0BADF00D);
    issue(1'b1, F3_W, 32'h10, 32'h13579BDF, 5'd12, d, e, m);
    issue(1'b0, F3_W, 32'h10, 32'h0, 5'd13, d, e, m);
    chk("b2b_lw", d, 32'h13579BDF);

    for (int n = 0; n < 300; n++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) step();
      issue(1'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom,
            5'($urandom), d, e, m);
    end

    step();
    step();
    for (int i = 0; i < 16; i++) chk("mem_word", dmem[i], ref_mem[i]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #(NC * 10);
    n_fail++;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
